// File: rtl/dmux_1_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : dmux_1_n_stream
// Brief    : 1-to-N valid/ready stream demultiplexer with explicit or
//            round-robin channel selection and illegal-select drop counter.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_1_n_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int SEL_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic [NUM_CH-1:0]            out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [SEL_WIDTH-1:0]         rr_ptr,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);

    localparam logic [SEL_WIDTH:0]   c_num_ch = (SEL_WIDTH+1)'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] c_last   = SEL_WIDTH'(NUM_CH-1);

    logic [SEL_WIDTH-1:0]         w_tgt;
    logic                         w_legal;
    logic                         w_ready;
    logic                         w_acc;
    logic [NUM_CH-1:0]            w_hit;
    logic [NUM_CH-1:0]            w_push;
    logic [NUM_CH-1:0]            w_pop;
    logic [NUM_CH-1:0]            r_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] r_data;
    logic [SEL_WIDTH-1:0]         r_rr_ptr;
    logic [CNT_WIDTH-1:0]         r_drop_cnt;

    assign w_tgt   = mode ? r_rr_ptr : sel;
    assign w_legal = {1'b0, w_tgt} < c_num_ch;

    // An illegal target hits no channel, so it can never be blocked.
    assign w_ready = ~|(w_hit & r_valid & ~out_ready);
    assign w_acc   = in_valid & w_ready;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            localparam logic [SEL_WIDTH-1:0] c_idx = SEL_WIDTH'(k);

            assign w_hit[k]  = (w_tgt == c_idx);
            assign w_push[k] = w_acc & w_hit[k];
            assign w_pop[k]  = r_valid[k] & out_ready[k];

            // Push wins over pop so a simultaneous pop/push reloads without a bubble.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid[k]                           <= 1'b0;
                    r_data[k*DATA_WIDTH +: DATA_WIDTH]   <= '0;
                end else if (w_push[k]) begin
                    r_valid[k]                           <= 1'b1;
                    r_data[k*DATA_WIDTH +: DATA_WIDTH]   <= in_data;
                end else if (w_pop[k]) begin
                    r_valid[k]                           <= 1'b0;
                    r_data[k*DATA_WIDTH +: DATA_WIDTH]   <= '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (mode && w_acc) begin
            r_rr_ptr <= (r_rr_ptr == c_last) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_acc && !w_legal && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign rr_ptr    = r_rr_ptr;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dmux_1_n_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmux_1_n_stream
// Brief    : Scenario tasks plus a negedge reference model / scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmux_1_n_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [2:0]  out_valid;
    logic [47:0] out_data;
    logic [2:0]  out_ready;
    logic [1:0]  rr_ptr;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    logic [2:0]  m_valid;
    logic [1:0]  m_ptr;
    logic [7:0]  m_drop;
    logic [1:0]  m_t;
    logic        m_legal;
    logic        m_er;
    logic [15:0] m_exp;
    logic [15:0] q [3][$];

    dmux_1_n_stream #(
        .DATA_WIDTH (16),
        .NUM_CH     (3),
        .SEL_WIDTH  (2),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lane(input int k);
        return out_data[k*16 +: 16];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        m_valid = '0;
        m_ptr   = '0;
        m_drop  = '0;
        for (int k = 0; k < 3; k++) q[k].delete();
    endtask

    // Reference model: checks the current cycle, then predicts the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                m_t     = mode ? m_ptr : sel;
                m_legal = (m_t < 2'd3);
                m_er    = !m_legal || !m_valid[m_t] || out_ready[m_t];
                n_checks++;
                if (in_ready !== m_er) begin
                    n_fail++;
                    $display("FAIL mon_in_ready: got %b expected %b", in_ready, m_er);
                end
                n_checks++;
                if (out_valid !== m_valid) begin
                    n_fail++;
                    $display("FAIL mon_out_valid: got %b expected %b", out_valid, m_valid);
                end
                n_checks++;
                if (rr_ptr !== m_ptr) begin
                    n_fail++;
                    $display("FAIL mon_rr_ptr: got %0d expected %0d", rr_ptr, m_ptr);
                end
                n_checks++;
                if (drop_cnt !== m_drop) begin
                    n_fail++;
                    $display("FAIL mon_drop_cnt: got %0d expected %0d", drop_cnt, m_drop);
                end
                for (int k = 0; k < 3; k++) begin
                    if (!out_valid[k]) begin
                        n_checks++;
                        if (lane(k) !== 16'h0) begin
                            n_fail++;
                            $display("FAIL mon_idle_lane%0d: got %h expected 0000", k, lane(k));
                        end
                    end
                    if (m_valid[k] && out_ready[k]) begin
                        n_checks++;
                        if (q[k].size() == 0) begin
                            n_fail++;
                            $display("FAIL mon_pop_lane%0d: got %h expected none (queue empty)", k, lane(k));
                        end else begin
                            m_exp = q[k].pop_front();
                            if (lane(k) !== m_exp) begin
                                n_fail++;
                                $display("FAIL mon_pop_lane%0d: got %h expected %h", k, lane(k), m_exp);
                            end
                        end
                        m_valid[k] = 1'b0;
                    end
                end
                if (in_valid && m_er) begin
                    if (m_legal) begin
                        q[m_t].push_back(in_data);
                        m_valid[m_t] = 1'b1;
                        if (mode) m_ptr = (m_ptr == 2'd2) ? 2'd0 : m_ptr + 2'd1;
                    end else if (m_drop != 8'hFF) begin
                        m_drop = m_drop + 8'd1;
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 1'b0;
        in_data = '0; out_ready = '0;
        repeat (3) tick;
        n_checks++;
        if (out_valid !== 3'b000 || out_data !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b data=%h expected 000/0", out_valid, out_data);
        end
        n_checks++;
        if (rr_ptr !== 2'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got ptr=%0d drop=%0d expected 0/0", rr_ptr, drop_cnt);
        end
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_explicit;
        out_ready = 3'b111; mode = 1'b0; sel = 2'd1;
        in_data = 16'h00A5; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 3'b010 || lane(1) !== 16'h00A5 || lane(0) !== 16'h0 || lane(2) !== 16'h0) begin
            n_fail++;
            $display("FAIL explicit_sel1: got valid=%b data=%h expected 010/0000_00a5_0000", out_valid, out_data);
        end
        tick;
        n_checks++;
        if (out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL explicit_drain: got %b expected 000", out_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_ptr;
        mode = 1'b1; out_ready = 3'b111;
        for (int i = 0; i < 5; i++) begin
            exp_ptr = 2'(i % 3);
            n_checks++;
            if (rr_ptr !== exp_ptr) begin
                n_fail++;
                $display("FAIL rr_ptr_beat%0d: got %0d expected %0d", i, rr_ptr, exp_ptr);
            end
            in_data = 16'(i + 1); in_valid = 1'b1;
            tick;
        end
        in_valid = 1'b0;
        n_checks++;
        if (rr_ptr !== 2'd2) begin
            n_fail++;
            $display("FAIL rr_ptr_final: got %0d expected 2", rr_ptr);
        end
        repeat (2) tick;
        mode = 1'b0;
    endtask

    task automatic test_backpressure;
        mode = 1'b0; sel = 2'd2; out_ready = 3'b011;
        in_data = 16'h0011; in_valid = 1'b1;
        tick;
        n_checks++;
        if (out_valid[2] !== 1'b1 || lane(2) !== 16'h0011) begin
            n_fail++;
            $display("FAIL bp_first_held: got v=%b d=%h expected 1/0011", out_valid[2], lane(2));
        end
        in_data = 16'h0022;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stall: got %b expected 0", in_ready);
        end
        tick;
        n_checks++;
        if (in_ready !== 1'b0 || lane(2) !== 16'h0011) begin
            n_fail++;
            $display("FAIL bp_stable: got rdy=%b d=%h expected 0/0011", in_ready, lane(2));
        end
        out_ready = 3'b111;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got %b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[2] !== 1'b1 || lane(2) !== 16'h0022) begin
            n_fail++;
            $display("FAIL bp_reload: got v=%b d=%h expected 1/0022", out_valid[2], lane(2));
        end
        tick;
    endtask

    task automatic test_drop;
        mode = 1'b0; sel = 2'd3; out_ready = 3'b111; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_data = 16'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL drop_ready_beat%0d: got %b expected 1", i, in_ready);
            end
            tick;
        end
        in_valid = 1'b0;
        n_checks++;
        if (drop_cnt !== 8'd255 || out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL drop_saturate: got cnt=%0d valid=%b expected 255/000", drop_cnt, out_valid);
        end
    endtask

    task automatic test_async_reset;
        mode = 1'b0; out_ready = 3'b000; in_valid = 1'b1;
        sel = 2'd0; in_data = 16'hAAAA;
        tick;
        sel = 2'd2; in_data = 16'hBBBB;
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 3'b101) begin
            n_fail++;
            $display("FAIL arst_setup: got %b expected 101", out_valid);
        end
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 3'b000 || out_data !== 48'h0 || rr_ptr !== 2'd0 || drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL arst_immediate: got v=%b d=%h p=%0d c=%0d expected all zero",
                     out_valid, out_data, rr_ptr, drop_cnt);
        end
        #1;
        rst = 1'b0;
        clear_model();
        mon_en = 1'b1;
        tick;
    endtask

    task automatic test_mode_switch;
        mode = 1'b0; sel = 2'd0; out_ready = 3'b110;
        in_data = 16'h0033; in_valid = 1'b1;
        tick;
        mode = 1'b1; in_data = 16'h0044;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_rr_stall: got %b expected 0", in_ready);
        end
        tick;
        n_checks++;
        if (rr_ptr !== 2'd0 || out_valid !== 3'b001) begin
            n_fail++;
            $display("FAIL sw_no_skip: got p=%0d v=%b expected 0/001", rr_ptr, out_valid);
        end
        mode = 1'b0; sel = 2'd1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_mode0_ready: got %b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 3'b011 || lane(1) !== 16'h0044 || rr_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL sw_accept: got v=%b d1=%h p=%0d expected 011/0044/0", out_valid, lane(1), rr_ptr);
        end
        out_ready = 3'b111;
        repeat (2) tick;
    endtask

    task automatic test_back_to_back;
        mode = 1'b1; out_ready = 3'b111; in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 16'h1000 + 16'(i);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_beat%0d: got %b expected 1", i, in_ready);
            end
            tick;
        end
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = 3'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            tick;
        end
        in_valid = 1'b0; out_ready = 3'b111;
        repeat (3) tick;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (q[k].size() != 0) begin
                n_fail++;
                $display("FAIL b2b_lost_ch%0d: got %0d words pending expected 0", k, q[k].size());
            end
        end
        n_checks++;
        if (out_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_drained: got %b expected 000", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_explicit();
        test_round_robin();
        test_backpressure();
        test_drop();
        test_async_reset();
        test_mode_switch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
